// File: rtl/traffic_light_param.sv
`default_nettype none
// ============================================================================
// Module : traffic_light_param
// Parameterised RED/PRE/GRN/YEL traffic light with pedestrian walk and a
// flashing-yellow standby mode.
// Rev    : 1.0
// ============================================================================
module traffic_light_param #(
    parameter int RED_CYC   = 10,
    parameter int PRE_CYC   = 2,
    parameter int GRN_CYC   = 8,
    parameter int YEL_CYC   = 5,
    parameter int MIN_GRN   = 3,
    parameter int FLASH_CYC = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       avl,
    input  logic       ped_req,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_RED = 2'd0,
        ST_PRE = 2'd1,
        ST_GRN = 2'd2,
        ST_YEL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_red_last   = CNT_W'(RED_CYC - 1);
    localparam logic [CNT_W-1:0] c_pre_last   = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] c_grn_last   = CNT_W'(GRN_CYC - 1);
    localparam logic [CNT_W-1:0] c_yel_last   = CNT_W'(YEL_CYC - 1);
    localparam logic [CNT_W-1:0] c_min_last   = CNT_W'(MIN_GRN - 1);
    localparam logic [CNT_W-1:0] c_flash_last = CNT_W'(FLASH_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pend_q, ped_pend_d;
    logic             flash_q, flash_d;
    logic             flash_mode_q, flash_mode_d;
    logic             red_q, red_d;
    logic             green_q, green_d;
    logic             blue_q, blue_d;
    logic             w_req;
    logic             w_enter;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ped_pend_d   = ped_pend_q;
        flash_d      = flash_q;
        flash_mode_d = flash_mode_q;
        red_d        = red_q;
        green_d      = green_q;
        blue_d       = blue_q;
        w_req        = ped_pend_q | ped_req;
        w_enter      = 1'b0;

        if (!avl) begin
            // Standby: lamps blink yellow, flash half-period timed with cnt
            state_d      = ST_RED;
            ped_pend_d   = 1'b0;
            blue_d       = 1'b0;
            flash_mode_d = 1'b1;
            if (!flash_mode_q) begin
                flash_d = 1'b1;
                cnt_d   = '0;
            end else if (cnt_q == c_flash_last) begin
                flash_d = ~flash_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            red_d   = flash_d;
            green_d = flash_d;
        end else if (flash_mode_q) begin
            // Leaving standby restarts a full RED phase
            state_d      = ST_RED;
            cnt_d        = '0;
            flash_mode_d = 1'b0;
            flash_d      = 1'b0;
            ped_pend_d   = ped_req;
            red_d        = 1'b1;
            green_d      = 1'b0;
            blue_d       = 1'b0;
        end else begin
            ped_pend_d = ped_pend_q | ped_req;
            case (state_q)
                ST_RED: if (cnt_q == c_red_last) begin
                    state_d = ST_PRE;
                    w_enter = 1'b1;
                end
                ST_PRE: if (cnt_q == c_pre_last) begin
                    state_d = ST_GRN;
                    w_enter = 1'b1;
                end
                ST_GRN: if ((cnt_q == c_grn_last) || (w_req && (cnt_q >= c_min_last))) begin
                    state_d = ST_YEL;
                    w_enter = 1'b1;
                end
                default: if (cnt_q == c_yel_last) begin
                    state_d = ST_RED;
                    w_enter = 1'b1;
                end
            endcase

            cnt_d = w_enter ? '0 : cnt_q + 1'b1;

            // The walk decision is latched once, on entry to RED
            if (w_enter && (state_d == ST_RED)) begin
                ped_pend_d = 1'b0;
                blue_d     = w_req;
            end else if (state_d != ST_RED) begin
                blue_d = 1'b0;
            end

            red_d   = (state_d != ST_GRN);
            green_d = (state_d != ST_RED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RED;
            cnt_q        <= '0;
            ped_pend_q   <= 1'b0;
            flash_q      <= 1'b0;
            flash_mode_q <= 1'b0;
            red_q        <= 1'b1;
            green_q      <= 1'b0;
            blue_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ped_pend_q   <= ped_pend_d;
            flash_q      <= flash_d;
            flash_mode_q <= flash_mode_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_param.sv
`default_nettype none
// ============================================================================
// Module : tb_traffic_light_param
// Directed self-checking bench: default instance plus an all-ones instance.
// Rev    : 1.0
// ============================================================================
module tb_traffic_light_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       avl, ped_req;
    logic       red, green, blue;
    logic [1:0] state;
    logic       avl_m, ped_m;
    logic       red_m, green_m, blue_m;
    logic [1:0] state_m;

    int checks = 0;
    int errors = 0;

    traffic_light_param u_dut (
        .clk     (clk),
        .rst     (rst),
        .avl     (avl),
        .ped_req (ped_req),
        .red     (red),
        .green   (green),
        .blue    (blue),
        .state   (state)
    );

    traffic_light_param #(
        .RED_CYC   (1),
        .PRE_CYC   (1),
        .GRN_CYC   (1),
        .YEL_CYC   (1),
        .MIN_GRN   (1),
        .FLASH_CYC (1),
        .CNT_W     (1)
    ) u_min (
        .clk     (clk),
        .rst     (rst),
        .avl     (avl_m),
        .ped_req (ped_m),
        .red     (red_m),
        .green   (green_m),
        .blue    (blue_m),
        .state   (state_m)
    );

    always #5 clk = ~clk;

    // {state, red, green, blue} expected for a normal-cycling phase
    function automatic logic [4:0] lamps(input logic [1:0] s, input logic b);
        return {s, (s != 2'd2), (s != 2'd0), b};
    endfunction

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; avl = 1'b0; ped_req = 1'b1;
        avl_m = 1'b1; ped_m = 1'b0;
        step();
        checks++;
        if ({state, red, green, blue} !== 5'b00_1_0_0) begin
            errors++;
            $display("FAIL reset: got %b expected %b", {state, red, green, blue}, 5'b00100);
        end
        rst = 1'b0; avl = 1'b1; ped_req = 1'b0;
    endtask

    task automatic test_normal;
        logic [1:0] s;
        int p;
        for (int i = 0; i < 50; i++) begin
            p = i % 25;
            s = (p < 10) ? 2'd0 : (p < 12) ? 2'd1 : (p < 20) ? 2'd2 : 2'd3;
            checks++;
            if ({state, red, green, blue} !== lamps(s, 1'b0)) begin
                errors++;
                $display("FAIL normal[%0d]: got %b expected %b", i, {state, red, green, blue}, lamps(s, 1'b0));
            end
            step();
        end
    endtask

    task automatic test_ped_short;
        step(13);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL ped_short_grn: got %0d expected 2", state);
        end
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({state, red, green, blue} !== lamps(2'd3, 1'b0)) begin
                errors++;
                $display("FAIL ped_short_yel[%0d]: got %b expected %b", k, {state, red, green, blue}, lamps(2'd3, 1'b0));
            end
            step();
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({state, red, green, blue} !== lamps(2'd0, 1'b1)) begin
                errors++;
                $display("FAIL ped_short_walk[%0d]: got %b expected %b", k, {state, red, green, blue}, lamps(2'd0, 1'b1));
            end
            step();
        end
        checks++;
        if ({state, red, green, blue} !== lamps(2'd1, 1'b0)) begin
            errors++;
            $display("FAIL ped_short_pre: got %b expected %b", {state, red, green, blue}, lamps(2'd1, 1'b0));
        end
    endtask

    task automatic test_ped_hold;
        step(7);
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL hold_grn5: got %0d expected 2", state);
        end
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL hold_yel: got %0d expected 3", state);
        end
        step(5);
        checks++;
        if ({state, red, green, blue} !== lamps(2'd0, 1'b1)) begin
            errors++;
            $display("FAIL hold_walk: got %b expected %b", {state, red, green, blue}, lamps(2'd0, 1'b1));
        end
        step(2);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        checks++;
        if (blue !== 1'b1) begin
            errors++;
            $display("FAIL hold_walk_mid: got %b expected 1", blue);
        end
        step(7);
        checks++;
        if ({state, red, green, blue} !== lamps(2'd1, 1'b0)) begin
            errors++;
            $display("FAIL hold_walk_len: got %b expected %b", {state, red, green, blue}, lamps(2'd1, 1'b0));
        end
        step(4);
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL hold_grn2: got %0d expected 2", state);
        end
        step();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL hold_short_grn: got %0d expected 3", state);
        end
        step(5);
        checks++;
        if ({state, red, green, blue} !== lamps(2'd0, 1'b1)) begin
            errors++;
            $display("FAIL hold_second_walk: got %b expected %b", {state, red, green, blue}, lamps(2'd0, 1'b1));
        end
    endtask

    task automatic test_flash;
        logic f;
        step(16);
        avl = 1'b0;
        step();
        checks++;
        if ({state, red, green, blue} !== 5'b00_1_1_0) begin
            errors++;
            $display("FAIL flash_entry: got %b expected %b", {state, red, green, blue}, 5'b00110);
        end
        for (int k = 0; k < 12; k++) begin
            f = ((k / 4) % 2) == 0;
            checks++;
            if ({state, red, green, blue} !== {2'd0, f, f, 1'b0}) begin
                errors++;
                $display("FAIL flash[%0d]: got %b expected %b", k, {state, red, green, blue}, {2'd0, f, f, 1'b0});
            end
            step();
        end
        avl = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({state, red, green, blue} !== lamps(2'd0, 1'b0)) begin
                errors++;
                $display("FAIL flash_exit_red[%0d]: got %b expected %b", k, {state, red, green, blue}, lamps(2'd0, 1'b0));
            end
            step();
        end
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL flash_exit_pre: got %0d expected 1", state);
        end
    endtask

    task automatic test_reset_mid;
        step(2);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        step(4);
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL rstmid_yel: got %0d expected 3", state);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({state, red, green, blue} !== lamps(2'd0, 1'b0)) begin
                errors++;
                $display("FAIL rstmid_red[%0d]: got %b expected %b", k, {state, red, green, blue}, lamps(2'd0, 1'b0));
            end
            step();
        end
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_pre: got %0d expected 1", state);
        end
    endtask

    task automatic test_min_params;
        logic f;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({state_m, red_m, green_m, blue_m} !== lamps(2'(k % 4), 1'b0)) begin
                errors++;
                $display("FAIL min_cycle[%0d]: got %b expected %b", k, {state_m, red_m, green_m, blue_m}, lamps(2'(k % 4), 1'b0));
            end
            step();
        end
        avl_m = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            f = (k % 2) == 0;
            checks++;
            if ({state_m, red_m, green_m, blue_m} !== {2'd0, f, f, 1'b0}) begin
                errors++;
                $display("FAIL min_flash[%0d]: got %b expected %b", k, {state_m, red_m, green_m, blue_m}, {2'd0, f, f, 1'b0});
            end
        end
        avl_m = 1'b1;
        step();
        checks++;
        if ({state_m, red_m, green_m, blue_m} !== lamps(2'd0, 1'b0)) begin
            errors++;
            $display("FAIL min_flash_exit: got %b expected %b", {state_m, red_m, green_m, blue_m}, lamps(2'd0, 1'b0));
        end
        step();
        checks++;
        if (state_m !== 2'd1) begin
            errors++;
            $display("FAIL min_after_exit: got %0d expected 1", state_m);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_ped_short();
        test_ped_hold();
        test_flash();
        test_reset_mid();
        test_min_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
